// File: rtl/cci_mpf_shim_lockstep_deq_ctrl.sv
// cci_mpf_shim_lockstep_deq_ctrl
//   Dequeue scheduler and QoS configuration sequencer for the lockstep c0/c1
//   Tx buffer. Advances the buffer head when both channels can accept it,
//   stages CSR-written QoS settings and applies them at a quiet point, and
//   tracks blocked-cycle statistics plus a sticky starvation watchdog.
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   head_not_empty             buffer head holds an entry
//   head_c0_valid/c1_valid     head entry carries a c0 / c1 request
//   c0_dn_almfull/c1_dn_almfull downstream almost-full per channel
//   csr_wr_en, csr_wr_data     QoS config write {enable, beat_delta, min_beat}
//   deqTx                      dequeue strobe (combinational)
//   setqos, setqos_*           one-cycle apply pulse with the applied values
//   cfg_busy                   config write pending or being applied
//   blocked_c0_cnt/c1_cnt      saturating blocked-cycle counters
//   stall_alarm                sticky starvation flag
module cci_mpf_shim_lockstep_deq_ctrl #(
  parameter int unsigned STALL_LIMIT     = 1024,
  parameter int unsigned QUIESCE_TIMEOUT = 64,
  parameter int unsigned CNT_BITS        = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                head_not_empty,
  input  logic                head_c0_valid,
  input  logic                head_c1_valid,
  input  logic                c0_dn_almfull,
  input  logic                c1_dn_almfull,
  input  logic                csr_wr_en,
  input  logic [16:0]         csr_wr_data,
  output logic                deqTx,
  output logic                setqos,
  output logic                setqos_enable,
  output logic [7:0]          setqos_beat_delta_threshold,
  output logic [7:0]          setqos_min_beat_threshold,
  output logic                cfg_busy,
  output logic [CNT_BITS-1:0] blocked_c0_cnt,
  output logic [CNT_BITS-1:0] blocked_c1_cnt,
  output logic                stall_alarm
);

  localparam int unsigned WAIT_W  = ($clog2(QUIESCE_TIMEOUT) < 1) ? 1 : $clog2(QUIESCE_TIMEOUT);
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [16:0] QOS_RESET = {1'b1, 8'd6, 8'd0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_APPLY
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [16:0]         r_shadow;
  logic [16:0]         w_shadow_nxt;
  logic [16:0]         r_qos;
  logic [CNT_BITS-1:0] r_cnt0;
  logic [CNT_BITS-1:0] r_cnt1;
  logic [STALL_W-1:0]  r_stall_run;
  logic                r_alarm;

  logic w_c0_ok;
  logic w_c1_ok;
  logic w_deq_allowed;
  logic w_blocked;
  logic w_quiesced;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_quiesced = !head_not_empty || (r_wait_cnt == WAIT_W'(QUIESCE_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (csr_wr_en) w_state_nxt = S_PEND;
      S_PEND:  if (w_quiesced) w_state_nxt = S_APPLY;
      S_APPLY: w_state_nxt = csr_wr_en ? S_PEND : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    setqos        = (r_state == S_APPLY);
    cfg_busy      = (r_state != S_IDLE);
    w_deq_allowed = (r_state != S_APPLY);
  end

  // ---------------------------------------------------------------- dequeue
  assign w_c0_ok   = !head_c0_valid || !c0_dn_almfull;
  assign w_c1_ok   = !head_c1_valid || !c1_dn_almfull;
  assign deqTx     = head_not_empty && w_c0_ok && w_c1_ok && w_deq_allowed;
  assign w_blocked = head_not_empty && !deqTx;

  // ---------------------------------------------------------------- config
  // Every write lands in the shadow regardless of state: last write wins.
  assign w_shadow_nxt = csr_wr_en ? csr_wr_data : r_shadow;

  always_ff @(posedge clk) begin
    if (reset) r_shadow <= QOS_RESET;
    else       r_shadow <= w_shadow_nxt;
  end

  // Load the applied copy on entry to APPLY so the outputs already carry the
  // shadow during the pulse, including a write landing in the final PEND cycle.
  always_ff @(posedge clk) begin
    if (reset)                       r_qos <= QOS_RESET;
    else if (w_state_nxt == S_APPLY) r_qos <= w_shadow_nxt;
  end

  assign setqos_enable               = r_qos[16];
  assign setqos_beat_delta_threshold = r_qos[15:8];
  assign setqos_min_beat_threshold   = r_qos[7:0];

  // Counts only while staying in PEND; writes in PEND do not restart it.
  always_ff @(posedge clk) begin
    if (reset)
      r_wait_cnt <= '0;
    else if ((r_state == S_PEND) && (w_state_nxt == S_PEND))
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    else
      r_wait_cnt <= '0;
  end

  // ---------------------------------------------------------------- statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_blocked && head_c0_valid && c0_dn_almfull && (r_cnt0 != '1))
        r_cnt0 <= r_cnt0 + CNT_BITS'(1);
      if (w_blocked && head_c1_valid && c1_dn_almfull && (r_cnt1 != '1))
        r_cnt1 <= r_cnt1 + CNT_BITS'(1);
    end
  end

  assign blocked_c0_cnt = r_cnt0;
  assign blocked_c1_cnt = r_cnt1;

  // ---------------------------------------------------------------- watchdog
  // Alarm is set on the edge where the run length reaches STALL_LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_run <= '0;
      r_alarm     <= 1'b0;
    end else if (w_blocked) begin
      if (r_stall_run != STALL_W'(STALL_LIMIT))
        r_stall_run <= r_stall_run + STALL_W'(1);
      if (r_stall_run == STALL_W'(STALL_LIMIT - 1))
        r_alarm <= 1'b1;
    end else begin
      r_stall_run <= '0;
    end
  end

  assign stall_alarm = r_alarm;

endmodule

// File: tb/tb_cci_mpf_shim_lockstep_deq_ctrl.sv
module tb_cci_mpf_shim_lockstep_deq_ctrl;

  localparam int unsigned SL = 1024;
  localparam int unsigned QT = 64;
  localparam int unsigned CB = 4;
  localparam int unsigned CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          head_not_empty, head_c0_valid, head_c1_valid;
  logic          c0_dn_almfull, c1_dn_almfull;
  logic          csr_wr_en;
  logic [16:0]   csr_wr_data;
  logic          deqTx, setqos, setqos_enable, cfg_busy, stall_alarm;
  logic [7:0]    setqos_beat_delta_threshold, setqos_min_beat_threshold;
  logic [CB-1:0] blocked_c0_cnt, blocked_c1_cnt;

  cci_mpf_shim_lockstep_deq_ctrl #(
    .STALL_LIMIT    (SL),
    .QUIESCE_TIMEOUT(QT),
    .CNT_BITS       (CB)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .head_not_empty             (head_not_empty),
    .head_c0_valid              (head_c0_valid),
    .head_c1_valid              (head_c1_valid),
    .c0_dn_almfull              (c0_dn_almfull),
    .c1_dn_almfull              (c1_dn_almfull),
    .csr_wr_en                  (csr_wr_en),
    .csr_wr_data                (csr_wr_data),
    .deqTx                      (deqTx),
    .setqos                     (setqos),
    .setqos_enable              (setqos_enable),
    .setqos_beat_delta_threshold(setqos_beat_delta_threshold),
    .setqos_min_beat_threshold  (setqos_min_beat_threshold),
    .cfg_busy                   (cfg_busy),
    .blocked_c0_cnt             (blocked_c0_cnt),
    .blocked_c1_cnt             (blocked_c1_cnt),
    .stall_alarm                (stall_alarm)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a pending write is tracked by its age (-1 = none),
  // an apply cycle by a flag; statistics as plain integers.
  bit          m_applying;
  int          m_pend_age;
  logic [16:0] m_shadow, m_applied;
  int unsigned m_cnt0, m_cnt1, m_run;
  bit          m_alarm;
  bit          seen_setqos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_applying = 0;
    m_pend_age = -1;
    m_shadow   = 17'h1_06_00;
    m_applied  = 17'h1_06_00;
    m_cnt0 = 0; m_cnt1 = 0; m_run = 0; m_alarm = 0;
  endtask

  function automatic bit exp_deq();
    bit c0_block = head_c0_valid && c0_dn_almfull;
    bit c1_block = head_c1_valid && c1_dn_almfull;
    return head_not_empty && !c0_block && !c1_block && !m_applying;
  endfunction

  task automatic check_outputs();
    logic [16:0] q = m_applying ? m_shadow : m_applied;
    chk("deqTx",       32'(deqTx),                       32'(exp_deq()));
    chk("setqos",      32'(setqos),                      32'(m_applying));
    chk("qos_enable",  32'(setqos_enable),               32'(q[16]));
    chk("qos_delta",   32'(setqos_beat_delta_threshold), 32'(q[15:8]));
    chk("qos_min",     32'(setqos_min_beat_threshold),   32'(q[7:0]));
    chk("cfg_busy",    32'(cfg_busy),                    32'(m_applying || (m_pend_age >= 0)));
    chk("blocked_c0",  32'(blocked_c0_cnt),              m_cnt0);
    chk("blocked_c1",  32'(blocked_c1_cnt),              m_cnt1);
    chk("stall_alarm", 32'(stall_alarm),                 32'(m_alarm));
    seen_setqos = setqos;
  endtask

  task automatic model_edge();
    bit blk;
    if (reset) begin
      model_reset();
      return;
    end
    blk = head_not_empty && !exp_deq();
    if (blk) begin
      if (head_c0_valid && c0_dn_almfull && m_cnt0 < CMAX) m_cnt0++;
      if (head_c1_valid && c1_dn_almfull && m_cnt1 < CMAX) m_cnt1++;
      m_run++;
      if (m_run >= SL) m_alarm = 1;
    end else begin
      m_run = 0;
    end
    if (m_applying) begin
      m_applied  = m_shadow;
      m_applying = 0;
      if (csr_wr_en) begin
        m_shadow   = csr_wr_data;
        m_pend_age = 0;
      end
    end else if (m_pend_age >= 0) begin
      if (csr_wr_en) m_shadow = csr_wr_data;
      if (!head_not_empty || m_pend_age == QT - 1) begin
        m_applying = 1;
        m_pend_age = -1;
      end else begin
        m_pend_age++;
      end
    end else if (csr_wr_en) begin
      m_shadow   = csr_wr_data;
      m_pend_age = 0;
    end
  endtask

  // Inputs are driven at posedge+1; checks run at posedge+2.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit hne, input bit c0v, input bit c1v,
                       input bit c0af, input bit c1af,
                       input bit wr, input logic [16:0] wd);
    head_not_empty = hne; head_c0_valid = c0v; head_c1_valid = c1v;
    c0_dn_almfull = c0af; c1_dn_almfull = c1af;
    csr_wr_en = wr; csr_wr_data = wd;
  endtask

  int seen_at;
  int pulses;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Reset state
    chk("rst_enable", 32'(setqos_enable), 1);
    chk("rst_delta",  32'(setqos_beat_delta_threshold), 6);
    chk("rst_min",    32'(setqos_min_beat_threshold), 0);

    // 1: c1 blocked 5 cycles, then released
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0, 1, 0, '0);
      step();
      chk("t1_blocked_deq", 32'(seen_setqos), 0);
    end
    drive(1, 1, 1, 0, 0, 0, '0);
    step();
    chk("t1_c1cnt", 32'(blocked_c1_cnt), 5);
    chk("t1_c0cnt", 32'(blocked_c0_cnt), 0);

    // 2: c0-only head ignores c1 almost-full
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 1, 0, '0);
      step();
    end
    chk("t2_c1cnt", 32'(blocked_c1_cnt), 5);
    chk("t2_c0cnt", 32'(blocked_c0_cnt), 0);

    // 3: empty buffer, config applies two cycles after the write
    drive(0, 0, 0, 0, 0, 1, 17'h1_0A_03);
    step();
    seen_at = -1;
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, '0);
      step();
      if (seen_setqos && seen_at < 0) seen_at = k;
    end
    chk("t3_pulse_at", 32'(seen_at), 2);
    chk("t3_enable", 32'(setqos_enable), 1);
    chk("t3_delta",  32'(setqos_beat_delta_threshold), 8'h0A);
    chk("t3_min",    32'(setqos_min_beat_threshold), 8'h03);

    // 4: busy buffer, timeout apply, second write wins
    seen_at = -1;
    for (int k = 0; k < 70; k++) begin
      if (k == 0)       drive(1, 1, 1, 0, 0, 1, 17'h0_11_22);
      else if (k == 30) drive(1, 1, 1, 0, 0, 1, 17'h1_33_44);
      else              drive(1, 1, 1, 0, 0, 0, '0);
      step();
      if (seen_setqos && seen_at < 0) seen_at = k;
    end
    chk("t4_pulse_at", 32'(seen_at), 65);
    chk("t4_enable", 32'(setqos_enable), 1);
    chk("t4_delta",  32'(setqos_beat_delta_threshold), 8'h33);
    chk("t4_min",    32'(setqos_min_beat_threshold), 8'h44);

    // 5: starvation watchdog and counter saturation
    for (int k = 0; k < int'(SL) - 1; k++) begin
      drive(1, 1, 1, 1, 1, 0, '0);
      step();
    end
    chk("t5_alarm_early", 32'(stall_alarm), 0);
    step();
    chk("t5_alarm_set", 32'(stall_alarm), 1);
    chk("t5_c0_sat", 32'(blocked_c0_cnt), CMAX);
    chk("t5_c1_sat", 32'(blocked_c1_cnt), CMAX);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 1, 0, 0, 0, '0);
      step();
    end
    chk("t5_alarm_sticky", 32'(stall_alarm), 1);

    // 6: reset during PEND discards the pending config
    drive(1, 1, 1, 0, 0, 1, 17'h0_55_66);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 1, 0, 0, 0, '0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      drive(1, 1, 1, 0, 0, 0, '0);
      step();
      if (seen_setqos) pulses++;
    end
    chk("t6_no_pulse", 32'(pulses), 0);
    chk("t6_busy",   32'(cfg_busy), 0);
    chk("t6_enable", 32'(setqos_enable), 1);
    chk("t6_delta",  32'(setqos_beat_delta_threshold), 6);
    chk("t6_min",    32'(setqos_min_beat_threshold), 0);
    chk("t6_alarm",  32'(stall_alarm), 0);

    // Randomized traffic and config writes against the model
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0), 17'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
